// File: rtl/osnt_sume_rx_pkt_arbiter_pkg.sv
// Shared definitions for the rx packet arbiter: FSM state encodings and width helper.
package osnt_sume_rx_arb_defs;

  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_SEND = 1'b1;

  // ceil(log2(n)), never below 1 so a 2-port build still gets a real index bit
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < 32'(n)) begin
        r = r + 1;
      end else begin
        r = r;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/osnt_sume_rx_pkt_arbiter_grant_select.sv
// Combinational round-robin pick: first requesting port at or above base, wrapping.
module osnt_rr_grant_select
  import osnt_sume_rx_arb_defs::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PTR_W     = clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     base,
  output logic [PTR_W-1:0]     grant,
  output logic                 any_req
);

  // Walk distances from farthest to nearest so the nearest requester is assigned last
  always_comb begin
    int idx;
    logic hit;
    idx   = 0;
    hit   = 1'b0;
    grant = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx   = (int'(base) + k) % NUM_PORTS;
      hit   = |(req & (NUM_PORTS'(1) << idx));
      grant = hit ? PTR_W'(idx) : grant;
    end
  end

  // Any eligible requester at all
  assign any_req = |req;

endmodule

// File: rtl/osnt_sume_rx_pkt_arbiter.sv
// Packet-granular round-robin merge of NUM_PORTS rx streams into one AXI-Stream.
// Optional per-port forwarded-packet counters are built when ARB_PKT_COUNT_EN is defined.
module osnt_sume_rx_pkt_arbiter
  import osnt_sume_rx_arb_defs::*;
#(
  parameter int NUM_PORTS          = 4,
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                                    axis_aclk,
  input  logic                                    axis_resetn,
  input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic [NUM_PORTS-1:0]                    s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                    s_axis_tlast,
  output logic [NUM_PORTS-1:0]                    s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]          m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]           m_axis_tuser,
  output logic                                    m_axis_tvalid,
  output logic                                    m_axis_tlast,
  input  logic                                    m_axis_tready,
  input  logic [NUM_PORTS-1:0]                    port_en,
  input  logic                                    clear,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]          pkt_count
);

  localparam int PTR_W  = clog2(NUM_PORTS);
  localparam int KEEP_W = C_AXIS_DATA_WIDTH / 8;

  logic [0:0]       state_r;
  logic [PTR_W-1:0] grant_r;
  logic [PTR_W-1:0] rr_ptr_r;
  logic [PTR_W-1:0] sel_s;
  logic             any_req_s;
  logic             xfer_s;
  logic             last_xfer_s;

  osnt_rr_grant_select #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_grant_select (
    .req     (s_axis_tvalid & port_en),
    .base    (rr_ptr_r),
    .grant   (sel_s),
    .any_req (any_req_s)
  );

  assign xfer_s      = (state_r == ARB_SEND) & s_axis_tvalid[grant_r] & m_axis_tready;
  assign last_xfer_s = xfer_s & s_axis_tlast[grant_r];

  // Zero-latency output mux and tready demux; everything is quiet outside SEND
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tuser  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state_r == ARB_SEND) begin
      m_axis_tdata  = s_axis_tdata[grant_r*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
      m_axis_tkeep  = s_axis_tkeep[grant_r*KEEP_W +: KEEP_W];
      m_axis_tuser  = s_axis_tuser[grant_r*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
      m_axis_tvalid = s_axis_tvalid[grant_r];
      m_axis_tlast  = s_axis_tlast[grant_r];
      s_axis_tready = NUM_PORTS'(m_axis_tready) << grant_r;
    end else begin
      s_axis_tready = '0;
    end
  end

  // Arbitration FSM: grant is locked from the first beat to the tlast beat
  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn) begin
      state_r  <= ARB_IDLE;
      grant_r  <= '0;
      rr_ptr_r <= '0;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (any_req_s) begin
            grant_r <= sel_s;
            state_r <= ARB_SEND;
          end
        end
        ARB_SEND: begin
          if (last_xfer_s) begin
            state_r  <= ARB_IDLE;
            rr_ptr_r <= (grant_r == PTR_W'(NUM_PORTS - 1)) ? PTR_W'(0) : grant_r + PTR_W'(1);
          end
        end
        default: begin
          state_r <= ARB_IDLE;
        end
      endcase
    end
  end

`ifdef ARB_PKT_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt_r [NUM_PORTS];

  // Per-port packet counters; clear wins over a same-cycle increment
  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn || clear) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        cnt_r[p] <= '0;
      end
    end else if (last_xfer_s) begin
      cnt_r[grant_r] <= cnt_r[grant_r] + CNT_WIDTH'(1);
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_cnt_out
    assign pkt_count[p*CNT_WIDTH +: CNT_WIDTH] = cnt_r[p];
  end
`else
  logic unused_clear_s;

  assign pkt_count      = '0;
  assign unused_clear_s = clear;
`endif

endmodule
